lab6_seq_tracker: RTL and testbench



---
 rtl/lab6_seq_pkg.sv | 19 +
 rtl/lab6_sat_counter.sv | 38 +++
 rtl/lab6_seq_tracker.sv | 138 +++++++++++++
 tb/tb_lab6_seq_tracker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lab6_seq_pkg.sv
// rtl/lab6_seq_pkg.sv - shared FSM state type and default widths for the lab6 sequence tracker
package lab6_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam int DEF_CW        = 8;
  localparam int DEF_GW        = 8;
  localparam int DEF_BURST_GAP = 4;
  localparam int DEF_BURST_N   = 3;

  // Bits needed to hold a run length of 0..n.
  function automatic int run_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lab6_sat_counter.sv
// rtl/lab6_sat_counter.sv - up counter with sync clear, restart-to-one and saturation at all-ones
module lab6_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         restart_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (restart_i) begin
      count_d = W'(1);
    end else if (inc_i && (count_q != MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lab6_seq_tracker.sv
// rtl/lab6_seq_tracker.sv - match statistics (count, gap, min gap, burst alarm) for the "101" detector
// Optional min_gap register is built only when LAB6_SEQ_MINGAP_EN is defined.
module lab6_seq_tracker
  import lab6_seq_pkg::*;
#(
  parameter int CW        = DEF_CW,
  parameter int GW        = DEF_GW,
  parameter int BURST_GAP = DEF_BURST_GAP,
  parameter int BURST_N   = DEF_BURST_N
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          found,
  input  logic          clr,
  output logic [CW-1:0] match_count,
  output logic [GW-1:0] last_gap,
  output logic          gap_valid,
  output logic [GW-1:0] min_gap,
  output logic          burst
);

  localparam int              RW        = run_width(BURST_N);
  localparam logic [GW-1:0]   SHORT_LIM = GW'(BURST_GAP);
  localparam logic [RW-1:0]   RUN_MAX   = RW'(BURST_N);

  state_e          state_q, state_d;
  logic [GW-1:0]   gap_cnt;
  logic [GW-1:0]   last_gap_q, last_gap_d;
  logic            gap_valid_q, gap_valid_d;
  logic            burst_q, burst_d;
  logic [RW-1:0]   run_q, run_d;
  logic            take, record, gap_inc;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else if (found) begin
      state_d = ARMED;
    end
  end

  // A found coinciding with clr is dropped entirely.
  always_comb begin
    take    = found & ~clr;
    record  = take & (state_q == ARMED);
    gap_inc = ~clr & ~found & (state_q == ARMED);
  end

  lab6_sat_counter #(.W(CW)) u_match_cnt (
    .clk_i     (clock),
    .rst_ni    (rst_n),
    .clr_i     (clr),
    .restart_i (1'b0),
    .inc_i     (take),
    .count_o   (match_count)
  );

  lab6_sat_counter #(.W(GW)) u_gap_cnt (
    .clk_i     (clock),
    .rst_ni    (rst_n),
    .clr_i     (clr),
    .restart_i (take),
    .inc_i     (gap_inc),
    .count_o   (gap_cnt)
  );

  always_comb begin
    last_gap_d  = last_gap_q;
    gap_valid_d = 1'b0;
    run_d       = run_q;
    if (clr) begin
      last_gap_d = '0;
      run_d      = '0;
    end else if (record) begin
      last_gap_d  = gap_cnt;
      gap_valid_d = 1'b1;
      if (gap_cnt < SHORT_LIM) begin
        run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RW'(1);
      end else begin
        run_d = '0;
      end
    end
    burst_d = (run_d == RUN_MAX);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last_gap_q  <= '0;
      gap_valid_q <= 1'b0;
      run_q       <= '0;
      burst_q     <= 1'b0;
    end else begin
      last_gap_q  <= last_gap_d;
      gap_valid_q <= gap_valid_d;
      run_q       <= run_d;
      burst_q     <= burst_d;
    end
  end

  assign last_gap  = last_gap_q;
  assign gap_valid = gap_valid_q;
  assign burst     = burst_q;

`ifdef LAB6_SEQ_MINGAP_EN
  logic [GW-1:0] min_gap_q, min_gap_d;

  always_comb begin
    min_gap_d = min_gap_q;
    if (clr) begin
      min_gap_d = '1;
    end else if (record && (gap_cnt < min_gap_q)) begin
      min_gap_d = gap_cnt;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      min_gap_q <= '1;
    end else begin
      min_gap_q <= min_gap_d;
    end
  end

  assign min_gap = min_gap_q;
`else
  assign min_gap = '1;
`endif

endmodule

// File: tb/tb_lab6_seq_tracker.sv
// tb/tb_lab6_seq_tracker.sv - table, corner-case and random checks of two tracker builds (GW=8, GW=4)
module tb_lab6_seq_tracker;

`ifdef LAB6_SEQ_MINGAP_EN
  localparam bit MINGAP_EN = 1'b1;
`else
  localparam bit MINGAP_EN = 1'b0;
`endif

  logic       clock, rst_n, found, clr;
  logic [7:0] cnt_a, last_a, min_a;
  logic       gv_a, burst_a;
  logic [7:0] cnt_b;
  logic [3:0] last_b, min_b;
  logic       gv_b, burst_b;

  lab6_seq_tracker u_dut_a (
    .clock(clock), .rst_n(rst_n), .found(found), .clr(clr),
    .match_count(cnt_a), .last_gap(last_a), .gap_valid(gv_a),
    .min_gap(min_a), .burst(burst_a)
  );

  lab6_seq_tracker #(.CW(8), .GW(4)) u_dut_b (
    .clock(clock), .rst_n(rst_n), .found(found), .clr(clr),
    .match_count(cnt_b), .last_gap(last_b), .gap_valid(gv_b),
    .min_gap(min_b), .burst(burst_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int fails   = 0;
  int edge_n  = 0;

  // Reference model: edge indices of matches, plain arithmetic on gaps.
  int gmax[2] = '{255, 15};
  int m_cnt[2], m_last[2], m_gv[2], m_min[2], m_run[2], m_burst[2], m_armed[2], m_ledge[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_last[i] = 0; m_gv[i] = 0; m_min[i] = gmax[i];
      m_run[i] = 0; m_burst[i] = 0; m_armed[i] = 0; m_ledge[i] = 0;
    end
  endtask

  task automatic model_edge(input bit f, input bit c);
    int gap;
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      m_gv[i] = 0;
      if (c) begin
        m_cnt[i] = 0; m_last[i] = 0; m_min[i] = gmax[i];
        m_run[i] = 0; m_burst[i] = 0; m_armed[i] = 0;
      end else if (f) begin
        if (m_armed[i] != 0) begin
          gap = edge_n - m_ledge[i];
          if (gap > gmax[i]) gap = gmax[i];
          m_last[i] = gap;
          m_gv[i]   = 1;
          if (gap < 4) m_run[i] = (m_run[i] + 1 > 3) ? 3 : m_run[i] + 1;
          else         m_run[i] = 0;
          m_burst[i] = (m_run[i] == 3) ? 1 : 0;
          if (gap < m_min[i]) m_min[i] = gap;
        end
        if (m_cnt[i] < 255) m_cnt[i]++;
        m_ledge[i] = edge_n;
        m_armed[i] = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic check_all();
    check("count_a", 32'(cnt_a),   m_cnt[0]);
    check("last_a",  32'(last_a),  m_last[0]);
    check("gv_a",    32'(gv_a),    m_gv[0]);
    check("min_a",   32'(min_a),   MINGAP_EN ? m_min[0] : 255);
    check("burst_a", 32'(burst_a), m_burst[0]);
    check("count_b", 32'(cnt_b),   m_cnt[1]);
    check("last_b",  32'(last_b),  m_last[1]);
    check("gv_b",    32'(gv_b),    m_gv[1]);
    check("min_b",   32'(min_b),   MINGAP_EN ? m_min[1] : 15);
    check("burst_b", 32'(burst_b), m_burst[1]);
  endtask

  // Called at a falling edge; inputs held through the next rising edge.
  task automatic step(input bit f, input bit c);
    found = f;
    clr   = c;
    @(posedge clock);
    model_edge(f, c);
    #1;
    check_all();
    @(negedge clock);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_count", 32'(cnt_a), 0);
    check("arst_last",  32'(last_a), 0);
    check("arst_burst", 32'(burst_a), 0);
    check("arst_min",   32'(min_a), 255);
    check_all();
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    int at_edge;
    bit f;
    bit c;
    int cnt;
    int last;
    bit gv;
    bit burst;
    int mn;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{20, 1'b0, 1'b0, 0,  0, 1'b0, 1'b0, 255};
    tbl[1]  = '{30, 1'b1, 1'b0, 1,  0, 1'b0, 1'b0, 255};
    tbl[2]  = '{31, 1'b0, 1'b0, 1,  0, 1'b0, 1'b0, 255};
    tbl[3]  = '{32, 1'b1, 1'b0, 2,  2, 1'b1, 1'b0, 2};
    tbl[4]  = '{33, 1'b0, 1'b0, 2,  2, 1'b0, 1'b0, 2};
    tbl[5]  = '{34, 1'b1, 1'b0, 3,  2, 1'b1, 1'b0, 2};
    tbl[6]  = '{36, 1'b1, 1'b0, 4,  2, 1'b1, 1'b1, 2};
    tbl[7]  = '{37, 1'b0, 1'b0, 4,  2, 1'b0, 1'b1, 2};
    tbl[8]  = '{50, 1'b1, 1'b0, 5, 14, 1'b1, 1'b0, 2};
    tbl[9]  = '{70, 1'b1, 1'b1, 0,  0, 1'b0, 1'b0, 255};
    tbl[10] = '{75, 1'b1, 1'b0, 1,  0, 1'b0, 1'b0, 255};
    tbl[11] = '{76, 1'b1, 1'b0, 2,  1, 1'b1, 1'b0, 1};

    rst_n = 1'b0;
    found = 1'b0;
    clr   = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    check_all();

    for (int k = 0; k < 12; k++) begin
      while (edge_n < tbl[k].at_edge - 1) step(1'b0, 1'b0);
      step(tbl[k].f, tbl[k].c);
      check("tbl_count", 32'(cnt_a),   tbl[k].cnt);
      check("tbl_last",  32'(last_a),  tbl[k].last);
      check("tbl_gv",    32'(gv_a),    int'(tbl[k].gv));
      check("tbl_burst", 32'(burst_a), int'(tbl[k].burst));
      check("tbl_min",   32'(min_a),   MINGAP_EN ? tbl[k].mn : 255);
    end

    // Gap of 35 edges saturates the GW=4 build only.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (34) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("sat_gap_gw8", 32'(last_a), 35);
    check("sat_gap_gw4", 32'(last_b), 15);
    check("sat_gap_gv4", 32'(gv_b), 1);
    check("sat_gap_burst4", 32'(burst_b), 0);

    step(1'b0, 1'b1);
    repeat (260) step(1'b1, 1'b0);
    check("sat_count", 32'(cnt_a), 255);
    check("sat_count_gap", 32'(last_a), 1);
    check("sat_count_burst", 32'(burst_a), 1);

    step(1'b1, 1'b0);
    async_reset();
    step(1'b1, 1'b0);
    check("post_arst_count", 32'(cnt_a), 1);
    check("post_arst_gv", 32'(gv_a), 0);
    step(1'b1, 1'b0);
    check("post_arst_gap", 32'(last_a), 1);

    begin
      int thr;
      thr = 50;
      for (int n = 0; n < 3000; n++) begin
        if (n % 200 == 0) thr = $urandom_range(5, 95);
        step(($urandom_range(0, 99) < thr) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 2)   ? 1'b1 : 1'b0);
        if ($urandom_range(0, 499) == 0) async_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
